// File: rtl/iq_boxcar_integrator_pkg.sv
// iq_boxcar_integrator_pkg: shared state encodings, default widths and width check.
package iq_boxcar_integrator_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
    localparam int DEF_INPUT_WIDTH = 16;
    localparam int DEF_LEN_WIDTH = 10;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_ACC_MARGIN = DEF_ACC_WIDTH - DEF_INPUT_WIDTH - DEF_LEN_WIDTH;
    function automatic int acc_margin(input int acc_w, input int in_w, input int len_w);
        return acc_w - in_w - len_w;
    endfunction
endpackage

// File: rtl/iq_acc_lane.sv
// iq_acc_lane: signed clear/enable accumulator with a capture register for the final sum.
module iq_acc_lane #(
    parameter int IN_W = 16,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    cap,
    input  logic signed [IN_W-1:0]  din,
    output logic signed [ACC_W-1:0] fin,
    output logic signed [ACC_W-1:0] sum
);
    logic signed [ACC_W-1:0] acc;
    // fin already includes the current sample, so capture can share the edge of the last sample
    assign fin = acc + ACC_W'(din);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sum <= '0;
        end else begin
            if (clr) acc <= '0;
            else if (en) acc <= fin;
            if (cap) sum <= fin;
        end
    end
endmodule

// File: rtl/iq_boxcar_integrator.sv
// iq_boxcar_integrator: boxcar-integrates i/q samples over a start-triggered window.
// Define IQ_INTEG_DISC_EN to add the disc_thresh / state_bit discriminator.
module iq_boxcar_integrator
    import iq_boxcar_integrator_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        int_len,
    input  logic                        in_valid,
    input  logic signed [INPUT_WIDTH-1:0] i_in,
    input  logic signed [INPUT_WIDTH-1:0] q_in,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] i_sum,
    output logic signed [ACC_WIDTH-1:0] q_sum
`ifdef IQ_INTEG_DISC_EN
    ,
    input  logic signed [ACC_WIDTH-1:0] disc_thresh,
    output logic                        state_bit
`endif
);
    if (acc_margin(ACC_WIDTH, INPUT_WIDTH, LEN_WIDTH) < 0) begin : g_width_check
        $error("ACC_WIDTH must be >= INPUT_WIDTH + LEN_WIDTH");
    end
    state_t state, state_nxt;
    logic [LEN_WIDTH-1:0] cnt, len;
    logic start_ok, accept, last, unused;
    logic signed [ACC_WIDTH-1:0] i_fin, q_fin;
    assign start_ok = state == IDLE && start && int_len != '0;
    assign accept = state == ACCUM && in_valid;
    assign last = accept && LEN_WIDTH'(cnt + LEN_WIDTH'(1)) == len;
    assign busy = state != IDLE;
    assign out_valid = state == DONE;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = ACCUM;
            ACCUM:   if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            len <= '0;
        end else begin
            state <= state_nxt;
            cnt <= start_ok ? '0 : accept ? cnt + LEN_WIDTH'(1) : cnt;
            len <= start_ok ? int_len : len;
        end
    end
    iq_acc_lane #(.IN_W(INPUT_WIDTH), .ACC_W(ACC_WIDTH)) u_lane_i (
        .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(accept), .cap(last),
        .din(i_in), .fin(i_fin), .sum(i_sum)
    );
    iq_acc_lane #(.IN_W(INPUT_WIDTH), .ACC_W(ACC_WIDTH)) u_lane_q (
        .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(accept), .cap(last),
        .din(q_in), .fin(q_fin), .sum(q_sum)
    );
`ifdef IQ_INTEG_DISC_EN
    assign unused = ^q_fin;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_bit <= 1'b0;
        else if (last) state_bit <= i_fin > disc_thresh;
    end
`else
    assign unused = ^{i_fin, q_fin};
`endif
endmodule

// File: doc/iq_boxcar_integrator.md
Name: iq_boxcar_integrator

Overview:
- Downstream stage of the IQ down-mixer in the readout pipeline.
- Consumes the mixer's baseband i/q sample stream and integrates a fixed-length boxcar window per readout.
- Emits one integrated (I, Q) pair per window to the state-discrimination stage through a valid/ready handshake.

Parameters:
- INPUT_WIDTH, 16, signed width of each incoming i/q sample (matches the mixer OUTPUT_WIDTH).
- LEN_WIDTH, 10, width of the window-length field; maximum window is 2^LEN_WIDTH-1 samples.
- ACC_WIDTH, 32, signed accumulator and output width. Must be >= INPUT_WIDTH+LEN_WIDTH, so overflow is impossible. Elaboration fails via a generate-time check otherwise.

Ports:
- clk  in  1  single clock for the block.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a window; honoured only in IDLE.
- int_len  in  LEN_WIDTH  window length in samples; sampled on an accepted start.
- in_valid  in  1  a mixer sample is present this cycle.
- i_in  in  INPUT_WIDTH  signed I sample.
- q_in  in  INPUT_WIDTH  signed Q sample.
- busy  out  1  high in ACCUM or DONE.
- out_valid  out  1  integrated result available.
- out_ready  in  1  consumer accepts the result.
- i_sum  out  ACC_WIDTH  signed integrated I.
- q_sum  out  ACC_WIDTH  signed integrated Q.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - Accumulators, sample counter, latched length, i_sum, q_sum all 0.
  - out_valid=0, busy=0.
- FSM has three states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 and int_len!=0: latch int_len, clear both accumulators and the counter, go to ACCUM.
  - start=1 and int_len==0: ignored; stay in IDLE.
  - in_valid samples are discarded in IDLE.
- ACCUM:
  - Each cycle with in_valid=1: acc_i += sign-extended i_in, acc_q += sign-extended q_in, counter += 1.
  - Cycles with in_valid=0 are gaps. Nothing changes; gaps are allowed anywhere in the window.
  - When the sample being accepted makes counter == latched length:
    - Next edge loads i_sum/q_sum with the final sums, including that sample.
    - out_valid=1, state goes to DONE.
    - Latency: last sample accepted in cycle k gives out_valid=1 in cycle k+1.
  - start in ACCUM is ignored; int_len changes have no effect on the window in progress.
- DONE:
  - i_sum/q_sum/out_valid are held stable until out_valid && out_ready.
  - On the handshake edge: out_valid goes to 0, state goes to IDLE. i_sum/q_sum keep their last value.
  - in_valid samples in DONE are discarded.
  - start in DONE is ignored, including in the handshake cycle. A new window needs start in a later IDLE cycle.
- out_ready while out_valid=0 has no effect.
- Arithmetic: two's complement, full precision, no truncation or saturation.
- Reset asserted mid-window: immediate abort to the reset values; no partial result is emitted.

Optional Feature:
- Macro: IQ_INTEG_DISC_EN.
- Defined:
  - Adds parameter-free input port disc_thresh (ACC_WIDTH, signed) and output port state_bit (1).
  - state_bit is loaded in the same edge as i_sum, as (final acc_i > disc_thresh). disc_thresh is sampled at that edge.
  - state_bit resets to 0 and is held with i_sum.
- Not defined: neither port exists and no comparator logic is generated.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, ACCUM=2'd1, DONE=2'd2;
  - default widths INPUT_WIDTH/LEN_WIDTH/ACC_WIDTH;
  - the width-check constant ACC_WIDTH-INPUT_WIDTH-LEN_WIDTH.
- One natural sub-module, iq_acc_lane:
  - signed clear/enable accumulator with output capture register;
  - instantiated twice, once for I and once for Q;
  - the FSM and counter stay in the top.

Test Plan:
- Basic window: reset; start with int_len=4; samples i={100,-50,25,1}, q={-3,-3,-3,-3} back-to-back -> out_valid one cycle after the 4th sample, i_sum=76, q_sum=-12.
- Gapped input and backpressure: int_len=3; in_valid pattern 1,0,0,1,0,1 with i=q=-32768 each; out_ready held 0 for 5 cycles -> i_sum=q_sum=-98304, values stable throughout the stall, handshake returns to IDLE.
- Ignored events:
  - start with int_len=0 -> stays IDLE;
  - start mid-ACCUM -> window unaffected;
  - start in the handshake cycle -> ignored, next start accepted;
  - samples in IDLE/DONE -> not summed.
- Max length: int_len=1023 with i=+32767, q=-32768 -> i_sum=33520641, q_sum=-33521664, no wrap.
- Reset mid-window: rst_n pulsed low after 2 of 4 samples -> all outputs 0 immediately; next start with int_len=1, i=5 -> i_sum=5.
- IQ_INTEG_DISC_EN: disc_thresh=10 with final I sums 11, 10, -20 -> state_bit 1, 0, 0.
